// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t   : controller state encoding
//   W_DEF     : default operand/result width
//   cnt_width : iteration counter width for a given iteration count
package div_pkg;

  localparam int W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter must hold the value N_ITER itself (it is loaded and counted down).
  function automatic int cnt_width(input int n_iter);
    return (n_iter < 1) ? 1 : $clog2(n_iter + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(W_DEF);

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   i_rem  [W-1:0] : current (restored) partial remainder, always < divisor
//   i_bit          : next dividend bit shifted into the remainder
//   i_dvs  [W-1:0] : divisor magnitude
//   o_rem  [W-1:0] : next partial remainder (difference or restored value)
//   o_qbit         : quotient bit produced by this step
module div_sub_step
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic         o_qbit
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  // The shifted remainder needs W+1 bits; since it is below twice the
  // divisor, bit W of the difference is a reliable borrow/sign flag.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  assign o_qbit  = ~w_diff[W];

  // Either value is below the divisor, so the top bit is always zero here.
  assign o_rem   = o_qbit ? w_diff[W-1:0] : w_shift[W-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request pulse, sampled only in IDLE
//   s            : 0 = unsigned, 1 = two's complement signed
//   in1, in2     : dividend, divisor (latched on the accepting edge)
//   busy         : high from the cycle after acceptance until done
//   done         : one-cycle pulse, results valid in the same cycle
//   quot, remd   : quotient and remainder, held until the next accepted start
//   dz, ov       : divide-by-zero flag, signed overflow (MIN / -1) flag
//
// state   | meaning
// IDLE    | waiting for start
// CALC    | one restoring iteration per cycle, counter runs N_ITER..1
// FIX     | apply signs / divide-by-zero result, update outputs
// DONE    | done pulse, outputs valid
module div_seq
  import div_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int N_ITER = W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         s,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] remd,
  output logic         dz,
  output logic         ov
);

  localparam int               CNT_W    = cnt_width(N_ITER);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_rem_w;
  logic [W-1:0]     r_quo_w;
  logic [W-1:0]     r_dvs;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_ov_pend;
  logic [W-1:0]     r_quot;
  logic [W-1:0]     r_remd;
  logic             r_dz;
  logic             r_ov;

  logic [W-1:0]     w_in1_mag;
  logic [W-1:0]     w_in2_mag;
  logic             w_div_zero;
  logic             w_last;
  logic [W-1:0]     w_step_rem;
  logic             w_step_qbit;

  // Negating the most negative value yields itself, which is the correct
  // unsigned magnitude, so MIN needs no special handling here.
  assign w_in1_mag  = (s && in1[W-1]) ? -in1 : in1;
  assign w_in2_mag  = (s && in2[W-1]) ? -in2 : in2;
  assign w_div_zero = (in2 == '0);
  assign w_last     = (r_cnt == CNT_ONE);

  div_sub_step #(.W(W)) u_step (
    .i_rem  (r_rem_w),
    .i_bit  (r_quo_w[W-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_step_rem),
    .o_qbit (w_step_qbit)
  );

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = w_div_zero ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (w_last) w_next = ST_FIX;
      end
      ST_FIX: begin
        busy   = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rem_w   <= '0;
      r_quo_w   <= '0;
      r_dvs     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_ov_pend <= 1'b0;
      r_quot    <= '0;
      r_remd    <= '0;
      r_dz      <= 1'b0;
      r_ov      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt     <= w_div_zero ? '0 : CNT_LOAD;
            r_rem_w   <= '0;
            // On divide-by-zero the raw dividend is kept for the remainder.
            r_quo_w   <= w_div_zero ? in1 : w_in1_mag;
            r_dvs     <= w_in2_mag;
            r_qneg    <= s & (in1[W-1] ^ in2[W-1]);
            r_rneg    <= s & in1[W-1];
            r_ov_pend <= s & (in1 == MIN_NEG) & (&in2);
            r_dz      <= 1'b0;
            r_ov      <= 1'b0;
          end
        end
        ST_CALC: begin
          r_cnt   <= r_cnt - CNT_ONE;
          r_rem_w <= w_step_rem;
          // Dividend bits leave at the top while quotient bits enter below.
          r_quo_w <= {r_quo_w[W-2:0], w_step_qbit};
        end
        ST_FIX: begin
          r_cnt <= '0;
          if (r_dvs == '0) begin
            r_quot <= '1;
            r_remd <= r_quo_w;
            r_dz   <= 1'b1;
            r_ov   <= 1'b0;
          end else begin
            r_quot <= r_qneg ? -r_quo_w : r_quo_w;
            r_remd <= r_rneg ? -r_rem_w : r_rem_w;
            r_dz   <= 1'b0;
            r_ov   <= r_ov_pend;
          end
        end
        default: ;
      endcase
    end
  end

  assign quot = r_quot;
  assign remd = r_remd;
  assign dz   = r_dz;
  assign ov   = r_ov;

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL provide parameter W, default 32: operand and result width.
REQ-002 SHALL provide parameter N_ITER, default W: number of restoring iterations.
REQ-003 SHALL provide port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL provide port start, input, 1: request pulse; sampled only in IDLE.
REQ-006 SHALL provide port s, input, 1: 0 = unsigned, 1 = signed (two's complement).
REQ-007 SHALL provide port in1, input, W: dividend.
REQ-008 SHALL provide port in2, input, W: divisor.
REQ-009 SHALL provide port busy, output, 1: high from the cycle after start is accepted until done.
REQ-010 SHALL provide port done, output, 1: one-cycle pulse when results are valid.
REQ-011 SHALL provide port quot, output, W: quotient.
REQ-012 SHALL provide port remd, output, W: remainder.
REQ-013 SHALL provide port dz, output, 1: divide-by-zero flag.
REQ-014 SHALL provide port ov, output, 1: signed-overflow flag (most negative value / -1).

Function
REQ-015 SHALL implement states IDLE, CALC, FIX, DONE; IDLE->CALC on start, CALC->FIX after N_ITER iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-016 SHALL latch in1, in2 and s on the accepting edge; later changes to any input SHALL NOT affect the result.
REQ-017 SHALL, when s=1, divide operand magnitudes and set the quotient sign = sign(in1) XOR sign(in2) and the remainder sign = sign(in1), applying both in FIX.
REQ-018 SHALL use restoring division: per CALC cycle, shift the (W+1)-bit partial remainder left one bit, subtract the divisor magnitude, restore if negative, and shift the quotient bit in as 1 if non-negative, 0 otherwise.
REQ-019 SHALL assert done in DONE exactly N_ITER+2 cycles after the accepting edge (34 for W=32), with quot/remd/dz/ov valid in that same cycle.
REQ-020 SHALL hold quot, remd, dz and ov stable after done until the next accepted start.
REQ-021 SHALL ignore start while busy=1 or while in DONE.
REQ-022 SHALL, when in2=0, skip CALC (IDLE->FIX->DONE, done 2 cycles after accept) and output quot = all ones, remd = in1, dz=1, ov=0.
REQ-023 SHALL, when s=1, in1=0x80000000 and in2=0xFFFFFFFF, output quot=0x80000000, remd=0, ov=1, dz=0, with normal latency.
REQ-024 SHALL keep ov=0 whenever s=0.
REQ-025 SHALL clear dz and ov on every accepted start.
REQ-026 SHALL, if start and done coincide, not accept that start; start is accepted only in IDLE.

Reset
REQ-027 SHALL, on rst=1 asynchronously: state=IDLE, busy=0, done=0, quot=0, remd=0, dz=0, ov=0, iteration counter=0.
REQ-028 SHALL, on rst asserted mid-operation, abort without producing a done pulse; the first start after rst deassertion SHALL be processed normally.

Structure
REQ-029 SHALL place the state encoding, W default, and counter width ($clog2(N_ITER+1)) in a shared package div_pkg.
REQ-030 SHALL instantiate one sub-module div_sub_step: a combinational (W+1)-bit subtract-and-select step producing the next partial remainder and quotient bit.
REQ-031 SHALL use a single iteration counter; no per-bit unrolled datapath.

Verification
REQ-032 SHALL test s=0, in1=100, in2=7, start pulse -> done at cycle 34, quot=14, remd=2, dz=0, ov=0.
REQ-033 SHALL test s=1, in1=0xFFFFFFF9 (-7), in2=2 -> quot=0xFFFFFFFD (-3), remd=0xFFFFFFFF (-1).
REQ-034 SHALL test s=0, in1=0x12345678, in2=0 -> done at cycle 2, quot=0xFFFFFFFF, remd=0x12345678, dz=1.
REQ-035 SHALL test s=1, in1=0x80000000, in2=0xFFFFFFFF -> quot=0x80000000, remd=0, ov=1.
REQ-036 SHALL test second start at cycle 10 with different operands -> ignored; first result at cycle 34 unchanged, busy stays high throughout.
REQ-037 SHALL test rst pulse at cycle 15 of an operation -> busy=0, no done pulse; a new start of 9/3 then yields quot=3, remd=0 at cycle 34.
